// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read / 1-write register file.
//   DEFAULT_DATA_W : default register width
//   DEFAULT_ADDR_W : default address width (register count = 2**ADDR_W)
//   reg_idx_t      : register index at the default address width
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 4;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage : regfile_pkg

// File: rtl/onehot_decoder.sv
// Enabled binary-to-one-hot decoder.
// Ports:
//   en  : decode enable; out is all zero when low
//   sel : binary index, ADDR_W bits
//   out : one-hot result, 2**ADDR_W bits, bit sel set when en is high
module onehot_decoder #(
  parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    sel,
  output logic [2**ADDR_W-1:0] out
);

  always_comb begin
    out = '0;
    if (en) begin
      out[sel] = 1'b1;
    end
  end

endmodule : onehot_decoder

// File: rtl/regfile_2r1w.sv
// Parametrised register file: two registered read ports, one write port.
// Optional macro: REGFILE_BYPASS_EN -- when defined, a read of the address
// being written in the same cycle returns wdata instead of the old contents.
// Ports:
//   clk, rst           : single clock, synchronous active-high reset
//   we, waddr, wdata   : write port; commits at the rising edge
//   re_a, raddr_a      : read port A request; rdata_a updates one edge later
//   re_b, raddr_b      : read port B request; rdata_b updates one edge later
//   rdata_a, rdata_b   : registered read data; hold while re_x is low
//   wsel               : combinational one-hot write select (zero when no write)
//   valid_mask         : sticky per-register "written since reset" flags
// Interface protocol: there is no valid/ready handshake. Every request
// presented at an edge completes at that edge; the block never stalls.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re_a,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic                 re_b,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [DATA_W-1:0]    rdata_b,
  output logic [2**ADDR_W-1:0] wsel,
  output logic [2**ADDR_W-1:0] valid_mask
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_en;
  logic [DATA_W-1:0] rd_next_a;
  logic [DATA_W-1:0] rd_next_b;

  // Writes to the hard-wired zero register are dropped before decode, so
  // wsel, storage and valid_mask all see "no write".
  assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wdec (
    .en  (wr_en),
    .sel (waddr),
    .out (wsel)
  );

  // Read data selection. The zero-register rule is applied last so it wins
  // over forwarding (a zero-register write is suppressed anyway).
  always_comb begin
    rd_next_a = mem[raddr_a];
    rd_next_b = mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (waddr == raddr_a)) rd_next_a = wdata;
    if (wr_en && (waddr == raddr_b)) rd_next_b = wdata;
`else
`endif
    if ((ZERO_REG != 0) && (raddr_a == '0)) rd_next_a = '0;
    if ((ZERO_REG != 0) && (raddr_b == '0)) rd_next_b = '0;
  end

  // Storage: each register is loaded only when its wsel bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wsel[i]) mem[i] <= wdata;
      end
    end
  end

  // Sticky written-since-reset flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_mask <= '0;
    end else begin
      valid_mask <= valid_mask | wsel;
    end
  end

  // Registered read ports; each holds its value while its enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= rd_next_a;
      if (re_b) rdata_b <= rd_next_b;
    end
  end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w (default parameters: 16-bit data, 16 registers,
// zero register enabled). Directed table of vectors with hand-written
// expectations, then randomized traffic checked against a behavioural model.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  localparam int DW = 16;
  localparam int NR = 16;

`ifdef REGFILE_BYPASS_EN
  localparam logic [DW-1:0] SAME_CYC = 16'h5678;
`else
  localparam logic [DW-1:0] SAME_CYC = 16'h1234;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b0;
  logic            we = 1'b0;
  reg_idx_t        waddr = '0;
  logic [DW-1:0]   wdata = '0;
  logic            re_a = 1'b0;
  reg_idx_t        raddr_a = '0;
  logic [DW-1:0]   rdata_a;
  logic            re_b = 1'b0;
  reg_idx_t        raddr_b = '0;
  logic [DW-1:0]   rdata_b;
  logic [NR-1:0]   wsel;
  logic [NR-1:0]   valid_mask;

  regfile_2r1w dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re_a       (re_a),
    .raddr_a    (raddr_a),
    .rdata_a    (rdata_a),
    .re_b       (re_b),
    .raddr_b    (raddr_b),
    .rdata_b    (rdata_b),
    .wsel       (wsel),
    .valid_mask (valid_mask)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic          rst;
    logic          we;
    reg_idx_t      waddr;
    logic [DW-1:0] wdata;
    logic          re_a;
    reg_idx_t      raddr_a;
    logic          re_b;
    reg_idx_t      raddr_b;
    logic          has_exp;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [NR-1:0] exp_vm;
    logic [NR-1:0] exp_wsel;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input int wa,
                              input logic [DW-1:0] wd, input logic ra_en,
                              input int ra, input logic rb_en, input int rb,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                              input logic [NR-1:0] evm, input logic [NR-1:0] ews);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = reg_idx_t'(wa); v.wdata = wd;
    v.re_a = ra_en; v.raddr_a = reg_idx_t'(ra);
    v.re_b = rb_en; v.raddr_b = reg_idx_t'(rb);
    v.has_exp = 1'b1;
    v.exp_a = ea; v.exp_b = eb; v.exp_vm = evm; v.exp_wsel = ews;
    return v;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_mem [NR];
  logic [DW-1:0] m_a, m_b;
  logic [NR-1:0] m_vm;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
    end
  endtask

  function automatic logic write_allowed(input logic w, input reg_idx_t a);
    return w && (a != 0);
  endfunction

  function automatic logic [NR-1:0] model_wsel(input logic w, input reg_idx_t a);
    return write_allowed(w, a) ? (NR'(1) << a) : '0;
  endfunction

  function automatic logic [DW-1:0] model_read(input reg_idx_t ra);
    if (ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write_allowed(we, waddr) && waddr == ra) return wdata;
`endif
    return m_mem[ra];
  endfunction

  task automatic model_edge();
    logic [DW-1:0] na, nb;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_a = '0; m_b = '0; m_vm = '0;
    end else begin
      na = re_a ? model_read(raddr_a) : m_a;
      nb = re_b ? model_read(raddr_b) : m_b;
      if (write_allowed(we, waddr)) begin
        m_mem[waddr] = wdata;
        m_vm[waddr] = 1'b1;
      end
      m_a = na; m_b = nb;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
    re_a = v.re_a; raddr_a = v.raddr_a; re_b = v.re_b; raddr_b = v.raddr_b;
    n_vec++;
    #1;
    check("wsel_model", wsel, model_wsel(we, waddr));
    if (v.has_exp) check("wsel_table", wsel, v.exp_wsel);
    model_edge();
    exp_q.push_back(m_a);
    exp_q.push_back(m_b);
    @(posedge clk);
    #1;
    check("rdata_a_model", rdata_a, exp_q.pop_front());
    check("rdata_b_model", rdata_b, exp_q.pop_front());
    check("valid_mask_model", valid_mask, m_vm);
    if (v.has_exp) begin
      check("rdata_a_table", rdata_a, v.exp_a);
      check("rdata_b_table", rdata_b, v.exp_b);
      check("valid_mask_table", valid_mask, v.exp_vm);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs [$];

  initial begin
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_a = '0; m_b = '0; m_vm = '0;

    // Directed table: rst, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    //                 exp rdata_a, exp rdata_b, exp valid_mask, exp wsel
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    for (int i = 0; i < NR; i++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 1, i, 1, NR-1-i, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 1, 3, 16'hA5A5, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 16'h0008));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 3, 0, 0, 16'hA5A5, 16'h0000, 16'h0008, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 16'hA5A5, 16'h0000, 16'h0008, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0008, 16'h0000));
    vecs.push_back(mk(0, 1, 5, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0028, 16'h0020));
    vecs.push_back(mk(0, 1, 5, 16'h5678, 1, 5, 1, 5, SAME_CYC, SAME_CYC, 16'h0028, 16'h0020));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 5, 0, 0, 16'h5678, SAME_CYC, 16'h0028, 16'h0000));
    vecs.push_back(mk(0, 1, 6, 16'h00FF, 0, 0, 0, 0, 16'h5678, SAME_CYC, 16'h0068, 16'h0040));
    vecs.push_back(mk(0, 1, 7, 16'hBEEF, 1, 6, 0, 0, 16'h00FF, SAME_CYC, 16'h00E8, 16'h0080));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 3, 1, 7, 16'h00FF, 16'hBEEF, 16'h00E8, 16'h0000));
    vecs.push_back(mk(0, 1, 6, 16'h1111, 0, 5, 0, 7, 16'h00FF, 16'hBEEF, 16'h00E8, 16'h0040));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 6, 1, 6, 16'h00FF, 16'h1111, 16'h00E8, 16'h0000));
    vecs.push_back(mk(1, 1, 9, 16'hCAFE, 1, 9, 1, 6, 16'h0000, 16'h0000, 16'h0000, 16'h0200));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 9, 1, 9, 16'h0000, 16'h0000, 16'h0000, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Randomized traffic against the reference model only.
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      v.rst     = ($urandom_range(0, 63) == 0);
      v.we      = ($urandom_range(0, 3) != 0);
      v.waddr   = reg_idx_t'($urandom_range(0, NR-1));
      v.wdata   = DW'($urandom);
      v.re_a    = ($urandom_range(0, 3) != 0);
      v.raddr_a = ($urandom_range(0, 2) == 0) ? v.waddr : reg_idx_t'($urandom_range(0, NR-1));
      v.re_b    = ($urandom_range(0, 3) != 0);
      v.raddr_b = ($urandom_range(0, 3) == 0) ? v.raddr_a : reg_idx_t'($urandom_range(0, NR-1));
      v.has_exp = 1'b0;
      v.exp_a = '0; v.exp_b = '0; v.exp_vm = '0; v.exp_wsel = '0;
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_regfile_2r1w
